mlp_train_sequencer: RTL and testbench
======================================

Name: mlp_train_sequencer

Overview:
- Controller that sequences the 2-input / 1-output MLP datapath through supervised training, then a scored evaluation pass, then live inference.
- Holds a small programmable sample table and presents one sample at a time on the MLP values/expected inputs.
- Counts epochs and scores the final predictions.
- Sits between the board-level top (switches, LED) and the MLP instance, replacing ad-hoc epoch logic in the top.

Parameters:
- WIDTH, 32, bit width of the sfp fixed-point word.
- ONE_VAL, 32'h1000_0000, sfp encoding of 1.0 (drives switch inputs in inference).
- HALF_VAL, 32'h0800_0000, sfp encoding of 0.5 (classification threshold).
- NUM_SAMPLES, 4, number of rows in the sample table (≥1).
- EPOCH_W, 16, width of the epoch counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins training when in IDLE or DONE, ignored otherwise.
- num_epochs  input  EPOCH_W  epochs to train; sampled on the accepted start.
- cfg_we  input  1  sample-table write strobe; honoured only in IDLE or DONE.
- cfg_addr  input  $clog2(NUM_SAMPLES)  table row to write.
- cfg_in0  input  WIDTH  sample value 0.
- cfg_in1  input  WIDTH  sample value 1.
- cfg_exp  input  WIDTH  expected output.
- first_input  input  1  live switch 0 (inference).
- second_input  input  1  live switch 1 (inference).
- mlp_values0  output  WIDTH  to MLP values[0].
- mlp_values1  output  WIDTH  to MLP values[1].
- mlp_expected  output  WIDTH  to MLP expected[0].
- mlp_training  output  1  to MLP training.
- mlp_step  output  1  one-cycle pulse requesting one MLP forward (and backward, if training) step.
- mlp_step_done  input  1  MLP step complete; prediction is valid in this cycle.
- mlp_prediction  input  WIDTH  MLP prediction[0].
- busy  output  1  high in TRAIN_ISSUE, TRAIN_WAIT, EVAL_ISSUE and EVAL_WAIT.
- done  output  1  high in DONE.
- epoch  output  EPOCH_W  completed training epochs.
- correct  output  $clog2(NUM_SAMPLES+1)  correctly classified samples in the last evaluation pass.
- output_led  output  1  registered classification (prediction > HALF_VAL, signed compare).

Behaviour:
- State machine: IDLE, TRAIN_ISSUE, TRAIN_WAIT, EVAL_ISSUE, EVAL_WAIT, DONE.
- Reset: state = IDLE. All mlp_* outputs = 0, busy = 0, done = 0, epoch = 0, correct = 0, output_led = 0, sample index = 0. The sample table is NOT cleared.
- IDLE:
  - mlp_values and mlp_expected = 0.
  - start with num_epochs = 0 → EVAL_ISSUE.
  - start with num_epochs > 0 → TRAIN_ISSUE.
  - On an accepted start: epoch ← 0, index ← 0, correct ← 0.
- TRAIN_ISSUE (one cycle):
  - Drive row[index] on values/expected; mlp_training = 1; mlp_step = 1.
  - Next state: TRAIN_WAIT.
- TRAIN_WAIT:
  - Hold row[index] and mlp_training = 1.
  - On mlp_step_done: index++.
  - If index was NUM_SAMPLES-1: index ← 0 and epoch++.
  - If the incremented epoch == num_epochs → EVAL_ISSUE; otherwise → TRAIN_ISSUE.
- EVAL_ISSUE / EVAL_WAIT:
  - Same sequence as training with mlp_training = 0, one pass over all rows.
  - On each mlp_step_done: correct++ when (mlp_prediction > HALF_VAL) == (expected > HALF_VAL); output_led ← (mlp_prediction > HALF_VAL).
  - After the last row → DONE.
- DONE:
  - mlp_training = 0.
  - mlp_values0 = first_input ? ONE_VAL : 0; mlp_values1 = second_input ? ONE_VAL : 0.
  - mlp_step pulses every cycle in which no step is outstanding.
  - output_led updates on each mlp_step_done.
  - start restarts training (the table is kept; training continues from the current weights).
- Handshake:
  - At most one outstanding step.
  - mlp_step_done outside a *_WAIT state or DONE-outstanding is ignored.
  - mlp_step_done in the same cycle as mlp_step is not allowed (MLP latency ≥1).
- Simultaneous start and cfg_we in IDLE: the write takes effect, start is accepted, and the first issue reads the new row (write-first).
- cfg_we while busy: ignored, table unchanged.
- start while busy: ignored.
- rst mid-step: immediate return to IDLE; a late mlp_step_done after reset is ignored.
- epoch saturates at all-ones and never wraps.
- Compares are signed on WIDTH bits. Values equal to HALF_VAL classify as 0.

Test Plan:
- Reset, then load the AND table (00→0, 01→0, 10→0, 11→ONE) and start with num_epochs = 3, using a bench MLP with 2-cycle step_done → exactly 12 training steps then 4 eval steps; epoch = 3; done rises; busy drops the same cycle.
- Bench MLP returns prediction = expected on all rows → correct = 4. Bench returns HALF_VAL for every row → correct = 3 (only the three 0-rows match).
- start with num_epochs = 0 → no step has mlp_training = 1; 4 eval steps; DONE.
- In DONE, first_input = 1, second_input = 0 → mlp_values0 = ONE_VAL, mlp_values1 = 0; prediction 0x0900_0000 → output_led = 1; prediction 0x0800_0000 → output_led = 0.
- cfg_we and start during TRAIN_WAIT → table unchanged, epoch sequence unaffected.
- Assert rst during TRAIN_WAIT, then pulse mlp_step_done one cycle later → state IDLE, all outputs at reset values, no index advance; a new start runs normally.

Source files
------------

// File: rtl/mlp_train_sequencer.sv
// rtl/mlp_train_sequencer.sv - training, scored evaluation and live-inference sequencer for a 2-in/1-out MLP
//
// Purpose: holds a programmable sample table, steps the MLP through num_epochs
// training passes, one scored evaluation pass, then free-running inference
// driven by the live switches.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_epochs        run request (accepted in IDLE/DONE) and epoch count
//   cfg_we/addr/in0/in1/exp  sample-table write port (IDLE/DONE only)
//   first_input/second_input live switches used in DONE
//   mlp_values0/1, mlp_expected, mlp_training, mlp_step   drive to the MLP
//   mlp_step_done, mlp_prediction                         result from the MLP
//   busy, done, epoch, correct, output_led                status
module mlp_train_sequencer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] ONE_VAL     = 32'h1000_0000,
    parameter logic [WIDTH-1:0] HALF_VAL    = 32'h0800_0000,
    parameter int               NUM_SAMPLES = 4,
    parameter int               EPOCH_W     = 16,
    localparam int              AW          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int              CW          = $clog2(NUM_SAMPLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [EPOCH_W-1:0] num_epochs,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [WIDTH-1:0]   cfg_in0,
    input  logic [WIDTH-1:0]   cfg_in1,
    input  logic [WIDTH-1:0]   cfg_exp,
    input  logic               first_input,
    input  logic               second_input,
    output logic [WIDTH-1:0]   mlp_values0,
    output logic [WIDTH-1:0]   mlp_values1,
    output logic [WIDTH-1:0]   mlp_expected,
    output logic               mlp_training,
    output logic               mlp_step,
    input  logic               mlp_step_done,
    input  logic [WIDTH-1:0]   mlp_prediction,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch,
    output logic [CW-1:0]      correct,
    output logic               output_led
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN_ISSUE,
        S_TRAIN_WAIT,
        S_EVAL_ISSUE,
        S_EVAL_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_tab_in0 [NUM_SAMPLES];
    logic [WIDTH-1:0]   r_tab_in1 [NUM_SAMPLES];
    logic [WIDTH-1:0]   r_tab_exp [NUM_SAMPLES];
    logic [AW-1:0]      r_idx;
    logic [EPOCH_W-1:0] r_epoch;
    logic [EPOCH_W-1:0] r_num_epochs;
    logic [CW-1:0]      r_correct;
    logic               r_led;
    logic               r_pending;   // inference step outstanding in DONE

    logic               w_cfg_ok;
    logic               w_start_ok;
    logic               w_last;
    logic               w_pred_hi;
    logic               w_exp_hi;
    logic [EPOCH_W-1:0] w_epoch_inc;

    assign w_cfg_ok    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_ok  = start && w_cfg_ok;
    assign w_last      = (r_idx == AW'(NUM_SAMPLES - 1));
    assign w_pred_hi   = $signed(mlp_prediction) > $signed(HALF_VAL);
    assign w_exp_hi    = $signed(r_tab_exp[r_idx]) > $signed(HALF_VAL);
    // Saturating increment: the counter sticks at all-ones.
    assign w_epoch_inc = (r_epoch == '1) ? r_epoch : r_epoch + 1'b1;

    // Table is deliberately outside reset so a reset does not lose the program.
    always_ff @(posedge clk) begin
        if (cfg_we && w_cfg_ok && (int'(cfg_addr) < NUM_SAMPLES)) begin
            r_tab_in0[cfg_addr] <= cfg_in0;
            r_tab_in1[cfg_addr] <= cfg_in1;
            r_tab_exp[cfg_addr] <= cfg_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_epoch      <= '0;
            r_num_epochs <= '0;
            r_correct    <= '0;
            r_led        <= 1'b0;
            r_pending    <= 1'b0;
        end else if (w_start_ok) begin
            r_num_epochs <= num_epochs;
            r_epoch      <= '0;
            r_idx        <= '0;
            r_correct    <= '0;
            r_pending    <= 1'b0;
            r_state      <= (num_epochs == '0) ? S_EVAL_ISSUE : S_TRAIN_ISSUE;
        end else begin
            case (r_state)
                S_TRAIN_ISSUE: r_state <= S_TRAIN_WAIT;
                S_TRAIN_WAIT: begin
                    if (mlp_step_done) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_epoch <= w_epoch_inc;
                            r_state <= (w_epoch_inc == r_num_epochs) ? S_EVAL_ISSUE : S_TRAIN_ISSUE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_TRAIN_ISSUE;
                        end
                    end
                end
                S_EVAL_ISSUE: r_state <= S_EVAL_WAIT;
                S_EVAL_WAIT: begin
                    if (mlp_step_done) begin
                        if (w_pred_hi == w_exp_hi) begin
                            r_correct <= r_correct + 1'b1;
                        end
                        r_led <= w_pred_hi;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_EVAL_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    // A step goes out on every cycle with nothing outstanding.
                    if (!r_pending) begin
                        r_pending <= 1'b1;
                    end else if (mlp_step_done) begin
                        r_pending <= 1'b0;
                        r_led     <= w_pred_hi;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the registered state; the table read follows the
    // write-first rule because the row is looked up in the cycle after a write.
    always_comb begin
        mlp_values0  = '0;
        mlp_values1  = '0;
        mlp_expected = '0;
        mlp_training = 1'b0;
        mlp_step     = 1'b0;
        case (r_state)
            S_TRAIN_ISSUE, S_TRAIN_WAIT, S_EVAL_ISSUE, S_EVAL_WAIT: begin
                mlp_values0  = r_tab_in0[r_idx];
                mlp_values1  = r_tab_in1[r_idx];
                mlp_expected = r_tab_exp[r_idx];
                mlp_training = (r_state == S_TRAIN_ISSUE) || (r_state == S_TRAIN_WAIT);
                mlp_step     = (r_state == S_TRAIN_ISSUE) || (r_state == S_EVAL_ISSUE);
            end
            S_DONE: begin
                mlp_values0 = first_input  ? ONE_VAL : '0;
                mlp_values1 = second_input ? ONE_VAL : '0;
                mlp_step    = !r_pending;
            end
            default: ;
        endcase
    end

    assign busy       = (r_state == S_TRAIN_ISSUE) || (r_state == S_TRAIN_WAIT) ||
                        (r_state == S_EVAL_ISSUE)  || (r_state == S_EVAL_WAIT);
    assign done       = (r_state == S_DONE);
    assign epoch      = r_epoch;
    assign correct    = r_correct;
    assign output_led = r_led;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// tb/tb_mlp_train_sequencer.sv - self-checking bench for mlp_train_sequencer
module tb_mlp_train_sequencer;

    localparam int          N    = 4;
    localparam int          EW   = 16;
    localparam logic [31:0] ONE  = 32'h1000_0000;
    localparam logic [31:0] HALF = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_epochs = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_in0 = '0, cfg_in1 = '0, cfg_exp = '0;
    logic        first_input = 1'b0, second_input = 1'b0;
    logic [31:0] mlp_values0, mlp_values1, mlp_expected, mlp_prediction;
    logic        mlp_training, mlp_step, mlp_step_done;
    logic        busy, done, output_led;
    logic [15:0] epoch;
    logic [2:0]  correct;

    mlp_train_sequencer #(
        .WIDTH(32), .ONE_VAL(ONE), .HALF_VAL(HALF), .NUM_SAMPLES(N), .EPOCH_W(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_epochs(num_epochs),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_in0(cfg_in0), .cfg_in1(cfg_in1),
        .cfg_exp(cfg_exp), .first_input(first_input), .second_input(second_input),
        .mlp_values0(mlp_values0), .mlp_values1(mlp_values1), .mlp_expected(mlp_expected),
        .mlp_training(mlp_training), .mlp_step(mlp_step), .mlp_step_done(mlp_step_done),
        .mlp_prediction(mlp_prediction), .busy(busy), .done(done), .epoch(epoch),
        .correct(correct), .output_led(output_led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cls(input logic [31:0] x);
        return $signed(x) > $signed(HALF);
    endfunction

    // Bench copy of the sample table (what the DUT is supposed to hold).
    logic [31:0] t0 [N];
    logic [31:0] t1 [N];
    logic [31:0] te [N];

    // Behavioural MLP: fixed 2-cycle latency, prediction chosen by mode.
    typedef struct {
        bit          trn;
        bit          dn;
        logic [31:0] v0, v1, ex, pred;
    } step_t;
    step_t       log_q[$];
    int          mode = 0;          // 0 echo expected, 1 HALF, 2 fixed, 3 random
    logic [31:0] fixed_pred = '0;
    bit          mlp_en = 1'b1;
    bit          man_done = 1'b0;
    bit          auto_done = 1'b0;
    int          cnt = 0;
    logic [31:0] q_pred = '0;
    logic [31:0] pend_pred = '0;

    assign mlp_step_done  = auto_done | man_done;
    assign mlp_prediction = pend_pred;

    function automatic logic [31:0] pick_pred(input logic [31:0] ex);
        case (mode)
            0: return ex;
            1: return HALF;
            2: return fixed_pred;
            default: begin
                case ($urandom_range(0, 4))
                    0: return HALF;
                    1: return HALF + 32'd1;
                    2: return ONE;
                    3: return 32'd0;
                    default: return $urandom;
                endcase
            end
        endcase
    endfunction

    always @(negedge clk) begin : mlp_model
        step_t s;
        if (!mlp_en) begin
            cnt       = 0;
            auto_done = 1'b0;
        end else begin
            auto_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    auto_done = 1'b1;
                    pend_pred = q_pred;
                end
            end
            if (mlp_step) begin
                q_pred = pick_pred(mlp_expected);
                cnt    = 2;
                s.trn  = mlp_training;
                s.dn   = done;
                s.v0   = mlp_values0;
                s.v1   = mlp_values1;
                s.ex   = mlp_expected;
                s.pred = q_pred;
                log_q.push_back(s);
            end
        end
    end

    task automatic cfg_write(input int a, input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] e);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_in0 = x0; cfg_in1 = x1; cfg_exp = e;
        t0[a] = x0; t1[a] = x1; te[a] = e;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic kick(input int ep);
        log_q.delete();
        @(posedge clk); #1;
        num_epochs = 16'(ep); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        bit pb   = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            pb = busy;
        end
        chk({tag, " reached_done"}, 64'(seen), 64'd1);
        if (seen) chk({tag, " busy_drop"}, {62'd0, busy, pb}, 64'b01);
    endtask

    task automatic wait_train_wait(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy && mlp_training && !mlp_step) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " saw_train_wait"}, 64'(seen), 64'd1);
    endtask

    // Expected step stream: ep passes over rows 0..N-1 with training, then one
    // pass without; score from the bench table and the predictions returned.
    task automatic verify(input string tag, input int ep, output int ntr, output int cor);
        int  k = 0;
        int  bad = 0;
        int  nev = 0;
        bit  last_cls = 1'b0;
        ntr = 0;
        cor = 0;
        foreach (log_q[i]) begin
            if (!log_q[i].dn) begin
                int row = k % N;
                bit exp_trn = (k < N * ep);
                if (log_q[i].trn != exp_trn || log_q[i].v0 !== t0[row] ||
                    log_q[i].v1 !== t1[row] || log_q[i].ex !== te[row]) bad++;
                if (log_q[i].trn) ntr++;
                else begin
                    nev++;
                    if (cls(log_q[i].pred) == cls(te[row])) cor++;
                    last_cls = cls(log_q[i].pred);
                end
                k++;
            end
        end
        chk({tag, " row_sequence_errors"}, 64'(bad), 64'd0);
        chk({tag, " train_steps"}, 64'(ntr), 64'(N * ep));
        chk({tag, " eval_steps"}, 64'(nev), 64'(N));
        chk({tag, " correct"}, 64'(correct), 64'(cor));
        chk({tag, " epoch"}, 64'(epoch), 64'(ep));
        chk({tag, " led"}, 64'(output_led), 64'(last_cls));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " epoch"}, 64'(epoch), 64'd0);
        chk({tag, " correct"}, 64'(correct), 64'd0);
        chk({tag, " led"}, 64'(output_led), 64'd0);
        chk({tag, " step_training"}, {62'd0, mlp_step, mlp_training}, 64'd0);
        chk({tag, " values"}, {mlp_values0, mlp_values1}, 64'd0);
        chk({tag, " expected"}, 64'(mlp_expected), 64'd0);
    endtask

    typedef struct {
        int ep;
        int md;
        int n_train;
        int n_eval;
        int n_correct;
    } vec_t;
    vec_t vecs[4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ntr, cor;
        vecs[0] = '{ep: 3, md: 0, n_train: 12, n_eval: 4, n_correct: 4};
        vecs[1] = '{ep: 3, md: 1, n_train: 12, n_eval: 4, n_correct: 3};
        vecs[2] = '{ep: 0, md: 0, n_train: 0,  n_eval: 4, n_correct: 4};
        vecs[3] = '{ep: 1, md: 1, n_train: 4,  n_eval: 4, n_correct: 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // AND table
        cfg_write(0, 32'd0, 32'd0, 32'd0);
        cfg_write(1, 32'd0, ONE,   32'd0);
        cfg_write(2, ONE,   32'd0, 32'd0);
        cfg_write(3, ONE,   ONE,   ONE);

        foreach (vecs[i]) begin
            string tag;
            tag  = $sformatf("vec%0d", i);
            mode = vecs[i].md;
            kick(vecs[i].ep);
            wait_done(tag);
            verify(tag, vecs[i].ep, ntr, cor);
            chk({tag, " train_steps_table"}, 64'(ntr), 64'(vecs[i].n_train));
            chk({tag, " correct_table"}, 64'(correct), 64'(vecs[i].n_correct));
        end

        // Live inference in DONE
        first_input = 1'b1; second_input = 1'b0;
        @(negedge clk);
        chk("infer values0", 64'(mlp_values0), 64'(ONE));
        chk("infer values1", 64'(mlp_values1), 64'd0);
        chk("infer training", 64'(mlp_training), 64'd0);
        mode = 2;
        fixed_pred = 32'h0900_0000; repeat (8) @(negedge clk);
        chk("infer led_0900", 64'(output_led), 64'd1);
        fixed_pred = 32'h0800_0000; repeat (8) @(negedge clk);
        chk("infer led_half", 64'(output_led), 64'd0);
        fixed_pred = 32'hF000_0000; repeat (8) @(negedge clk);
        chk("infer led_negative", 64'(output_led), 64'd0);
        first_input = 1'b0; second_input = 1'b1;
        @(negedge clk);
        chk("infer values_swapped", {mlp_values0, mlp_values1}, {32'd0, ONE});

        // cfg_we and start while training are ignored
        mode = 0;
        kick(3);
        wait_train_wait("busy_cfg");
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_in0 = 32'hDEAD_BEEF;
        cfg_in1 = 32'h1234_5678; cfg_exp = 32'h7FFF_FFFF;
        start = 1'b1; num_epochs = 16'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        wait_done("busy_cfg");
        verify("busy_cfg", 3, ntr, cor);

        // Reset mid-step with a late step_done
        kick(3);
        wait_train_wait("midrst");
        rst = 1'b1; mlp_en = 1'b0;
        @(negedge clk);
        rst = 1'b0; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check_reset("midrst");
        @(negedge clk);
        chk("midrst still_idle", {62'd0, busy, done}, 64'd0);
        mlp_en = 1'b1;
        kick(1);
        wait_done("after_rst");
        verify("after_rst", 1, ntr, cor);

        // Simultaneous start and table write in IDLE: the new row is used
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        log_q.delete();
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_in0 = ONE; cfg_in1 = 32'h0000_0042; cfg_exp = ONE;
        t0[0] = ONE; t1[0] = 32'h0000_0042; te[0] = ONE;
        start = 1'b1; num_epochs = 16'd1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        wait_done("write_first");
        verify("write_first", 1, ntr, cor);

        // Randomized runs against the reference model
        mode = 3;
        for (int r = 0; r < 6; r++) begin
            string tag;
            int    ep;
            tag = $sformatf("rand%0d", r);
            for (int a = 0; a < N; a++) begin
                logic [31:0] e;
                case ($urandom_range(0, 4))
                    0: e = 32'd0;
                    1: e = ONE;
                    2: e = HALF;
                    3: e = HALF + 32'd1;
                    default: e = $urandom;
                endcase
                cfg_write(a, $urandom_range(0, 1) ? ONE : 32'd0, $urandom_range(0, 1) ? ONE : 32'd0, e);
            end
            ep = $urandom_range(0, 2);
            kick(ep);
            wait_done(tag);
            verify(tag, ep, ntr, cor);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
